// File: rtl/quad_decoder_counter_if.sv
// Encoder-side bus for the quadrature decoder: phase inputs,
// controls and the decoded position outputs.
interface quad_decoder_counter_if #(
  parameter int WIDTH = 4
);
  logic             qa;
  logic             qb;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             direction;
  logic             step;
  logic             wrap;
  logic             err;
  logic             err_flag;

  modport master (
    output qa, qb, en, clr,
    input  count, direction, step, wrap, err, err_flag
  );

  modport slave (
    input  qa, qb, en, clr,
    output count, direction, step, wrap, err, err_flag
  );
endinterface

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder: synchronizes A/B, decodes Gray steps and
// keeps a wrapping up/down position count with error tracking.
module quad_decoder_counter #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  quad_decoder_counter_if.slave bus
);
  logic             qa1_q, qa1_d, sa_q, sa_d;
  logic             qb1_q, qb1_d, sb_q, sb_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       arm_q, arm_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             flag_q, flag_d;

  logic [1:0] cur;
  logic       armed;
  logic       up;
  logic       dn;
  logic       bad;

  assign cur   = {sa_q, sb_q};
  assign armed = (arm_q == 2'd3);
  assign bad   = ((prev_q ^ cur) == 2'b11);

  always_comb begin
    up = 1'b0;
    dn = 1'b0;
    case ({prev_q, cur})
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: up = 1'b1;
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: dn = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    qa1_d   = bus.qa;
    sa_d    = qa1_q;
    qb1_d   = bus.qb;
    sb_d    = qb1_q;
    prev_d  = cur;
    arm_d   = armed ? arm_q : arm_q + 2'd1;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    flag_d  = flag_q;
    if (bus.clr) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (armed) begin
      if (bad) begin
        err_d  = 1'b1;
        flag_d = 1'b1;
      end else if (bus.en && up) begin
        count_d = count_q + 1'b1;
        dir_d   = 1'b1;
        step_d  = 1'b1;
        wrap_d  = &count_q;
      end else if (bus.en && dn) begin
        count_d = count_q - 1'b1;
        dir_d   = 1'b0;
        step_d  = 1'b1;
        wrap_d  = ~|count_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      qa1_q   <= 1'b0;
      sa_q    <= 1'b0;
      qb1_q   <= 1'b0;
      sb_q    <= 1'b0;
      prev_q  <= 2'b00;
      arm_q   <= 2'd0;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      qa1_q   <= qa1_d;
      sa_q    <= sa_d;
      qb1_q   <= qb1_d;
      sb_q    <= sb_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.direction = dir_q;
  assign bus.step      = step_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;
  assign bus.err_flag  = flag_q;
endmodule

// File: tb/tb_quad_decoder_counter.sv
// Scoreboard bench for quad_decoder_counter: directed phase
// sequences push expected pulses, a monitor pops and compares.
module tb_quad_decoder_counter;
  localparam int W = 4;

  typedef struct {
    int         cyc;
    logic [W-1:0] cnt;
    logic       dir;
    logic       stp;
    logic       wrp;
    logic       er;
    logic       flg;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   wraps_seen;
  bit   mon_on;
  exp_t exp_q[$];

  logic [1:0]   m_prev;
  logic [W-1:0] m_cnt;
  logic         m_dir;
  logic         m_flag;

  quad_decoder_counter_if #(.WIDTH(W)) bus ();

  quad_decoder_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && (bus.step || bus.wrap || bus.err)) begin
      if (bus.wrap) wraps_seen = wraps_seen + 1;
      if (exp_q.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL unexpected_pulse: cyc=%0d step=%0b wrap=%0b err=%0b",
                 cyc, bus.step, bus.wrap, bus.err);
      end else begin
        exp_t r;
        r = exp_q.pop_front();
        chk("pulse_cycle", cyc, r.cyc);
        chk("count", int'(bus.count), int'(r.cnt));
        chk("direction", int'(bus.direction), int'(r.dir));
        chk("step", int'(bus.step), int'(r.stp));
        chk("wrap", int'(bus.wrap), int'(r.wrp));
        chk("err", int'(bus.err), int'(r.er));
        chk("err_flag", int'(bus.err_flag), int'(r.flg));
      end
    end
  end

  function automatic logic [1:0] up_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dn_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // called at a negedge; holds the new phase for 4 clocks
  task automatic drive(input logic [1:0] ph);
    exp_t r;
    logic up;
    logic dn;
    up = (up_next(m_prev) == ph);
    dn = (dn_next(m_prev) == ph);
    bus.qa = ph[1];
    bus.qb = ph[0];
    r.cyc = cyc + 3;
    if ((m_prev ^ ph) == 2'b11) begin
      m_flag = 1'b1;
      r.cnt = m_cnt; r.dir = m_dir;
      r.stp = 1'b0; r.wrp = 1'b0; r.er = 1'b1; r.flg = 1'b1;
      exp_q.push_back(r);
    end else if (bus.en && (up || dn)) begin
      r.wrp = up ? (m_cnt == '1) : (m_cnt == '0);
      m_cnt = up ? m_cnt + 1'b1 : m_cnt - 1'b1;
      m_dir = up;
      r.cnt = m_cnt; r.dir = m_dir;
      r.stp = 1'b1; r.er = 1'b0; r.flg = m_flag;
      exp_q.push_back(r);
    end
    m_prev = ph;
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_cnt  = '0;
    m_flag = 1'b0;
    @(negedge clk);
  endtask

  // valid step whose decode edge coincides with clr
  task automatic step_with_clr(input logic [1:0] ph);
    bus.qa = ph[1];
    bus.qb = ph[0];
    m_prev = ph;
    repeat (2) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_cnt  = '0;
    m_flag = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; wraps_seen = 0; mon_on = 1'b0;
    rst = 1'b0;
    bus.qa = 1'b1; bus.qb = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b1;
    mon_on = 1'b1;
    m_prev = 2'b11; m_cnt = '0; m_dir = 1'b0; m_flag = 1'b0;
    @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_direction", int'(bus.direction), 0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_err_flag", int'(bus.err_flag), 0);
    repeat (6) @(negedge clk);
    chk("armed_count", int'(bus.count), 0);
    chk("armed_err_flag", int'(bus.err_flag), 0);

    drive(2'b01);
    drive(2'b00);
    chk("pre_count", int'(bus.count), 2);
    clr_pulse();
    chk("clr_count", int'(bus.count), 0);
    chk("clr_keeps_dir", int'(bus.direction), 1);

    drive(2'b10);
    drive(2'b11);
    drive(2'b01);
    drive(2'b00);
    chk("up_count", int'(bus.count), 4);
    chk("up_dir", int'(bus.direction), 1);

    for (int i = 0; i < 11; i++) drive(up_next(m_prev));
    chk("at_max", int'(bus.count), 15);
    drive(up_next(m_prev));
    chk("wrap_up_count", int'(bus.count), 0);
    drive(dn_next(m_prev));
    chk("wrap_dn_count", int'(bus.count), 15);
    chk("wrap_dn_dir", int'(bus.direction), 0);
    chk("wrap_pulses", wraps_seen, 2);

    clr_pulse();
    drive(up_next(m_prev));
    drive(up_next(m_prev));
    chk("rev_up_count", int'(bus.count), 2);
    for (int i = 0; i < 3; i++) drive(dn_next(m_prev));
    chk("rev_dn_count", int'(bus.count), 15);
    chk("rev_dir", int'(bus.direction), 0);

    drive(m_prev ^ 2'b11);
    chk("ill_flag", int'(bus.err_flag), 1);
    chk("ill_count", int'(bus.count), 15);
    chk("ill_dir", int'(bus.direction), 0);
    drive(up_next(m_prev));
    drive(up_next(m_prev));
    chk("post_ill_count", int'(bus.count), 1);
    clr_pulse();
    chk("clr2_count", int'(bus.count), 0);
    chk("clr2_flag", int'(bus.err_flag), 0);
    chk("clr2_dir", int'(bus.direction), 1);

    bus.en = 1'b0;
    drive(dn_next(m_prev));
    drive(dn_next(m_prev));
    chk("en0_count", int'(bus.count), 0);
    chk("en0_dir", int'(bus.direction), 1);
    bus.en = 1'b1;
    drive(up_next(m_prev));
    chk("reen_count", int'(bus.count), 1);
    step_with_clr(up_next(m_prev));
    chk("stepclr_count", int'(bus.count), 0);

    drive(dn_next(m_prev));
    chk("pre_rst_count", int'(bus.count), 15);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_flag", int'(bus.err_flag), 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
